// File: rtl/router_pkg.sv
// router_pkg: shared flit and virtual-channel types for the router input stage
package router_pkg;
    localparam int FLIT_DATA_WIDTH = 32;
    typedef enum logic [1:0] {BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HEADTAIL = 2'b11} flit_type_e;
    typedef enum logic [1:0] {IDLE, VA_WAIT, ACTIVE} vc_state_e;
    localparam int DIR_LOCAL = 0;
    localparam int DIR_NORTH = 1;
    localparam int DIR_SOUTH = 2;
    localparam int DIR_EAST  = 3;
    localparam int DIR_WEST  = 4;
endpackage

// File: rtl/fifo.sv
// fifo: show-ahead synchronous FIFO; pushes while full and pops while empty are ignored
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/xy_route_compute.sv
// xy_route_compute: dimension-ordered (X then Y) one-hot output port for a destination router
module xy_route_compute import router_pkg::*; #(
    parameter int NUM_PORTS = 5,
    parameter int NUM_ROUTERS = 16,
    parameter int ROUTER_PER_ROW = 4,
    parameter int ROUTER_ID = 0,
    localparam int ROUTER_ID_BITS = $clog2(NUM_ROUTERS)
) (
    input  logic [ROUTER_ID_BITS-1:0] dest,
    output logic [NUM_PORTS-1:0]      route
);
    localparam int ROW = ROUTER_ID / ROUTER_PER_ROW;
    localparam int COL = ROUTER_ID % ROUTER_PER_ROW;
    int dest_row, dest_col, dir;
    always_comb begin
        dest_row = int'(dest) / ROUTER_PER_ROW;
        dest_col = int'(dest) % ROUTER_PER_ROW;
        dir = dest_col > COL ? DIR_EAST : dest_col < COL ? DIR_WEST :
              dest_row > ROW ? DIR_SOUTH : dest_row < ROW ? DIR_NORTH : DIR_LOCAL;
        route = NUM_PORTS'(1) << dir;
    end
endmodule

// File: rtl/vc_input_unit.sv
// vc_input_unit: per-VC buffering, XY routing and allocation requests for one router input port
module vc_input_unit #(
    parameter int NUM_VC = 4,
    parameter int BUFFER_DEPTH = 8,
    parameter int FLIT_DATA_WIDTH = router_pkg::FLIT_DATA_WIDTH,
    parameter int NUM_PORTS = 5,
    parameter int NUM_ROUTERS = 16,
    parameter int ROUTER_PER_ROW = 4,
    parameter int ROUTER_ID = 0,
    localparam int VC_BITS = $clog2(NUM_VC),
    localparam int ROUTER_ID_BITS = $clog2(NUM_ROUTERS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [FLIT_DATA_WIDTH-1:0]       in_flit,
    input  logic                             in_valid,
    input  logic [VC_BITS-1:0]               in_vc,
    output logic [NUM_VC-1:0][NUM_PORTS-1:0] vc_route,
    output logic [NUM_VC-1:0]                va_req,
    input  logic [NUM_VC-1:0]                va_grant,
    output logic [NUM_VC-1:0]                sa_req,
    input  logic                             rd_valid,
    input  logic [VC_BITS-1:0]               rd_vc,
    output logic [FLIT_DATA_WIDTH-1:0]       out_flit,
    output logic                             out_flit_valid,
    output logic                             credit_valid,
    output logic [VC_BITS-1:0]               credit_vc,
    output logic                             overflow_err,
    output logic                             protocol_err
);
    import router_pkg::*;
    localparam int W = FLIT_DATA_WIDTH;
    logic [W-1:0] front [NUM_VC];
    logic [NUM_VC-1:0] full, empty, idle, active, disc;
    logic rd_ok, disc_any, disc_go, pop_any;
    logic [VC_BITS-1:0] disc_vc, pop_vc;
    assign rd_ok = rd_valid && active[rd_vc] && !empty[rd_vc];
    always_comb begin
        disc_any = 1'b0;
        disc_vc = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (disc[i]) begin
                disc_any = 1'b1;
                disc_vc = VC_BITS'(i);
            end
        end
    end
    assign disc_go = disc_any && !rd_ok;
    assign pop_any = rd_ok || disc_any;
    assign pop_vc = rd_ok ? rd_vc : disc_vc;
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_state_e st, st_nxt;
        logic [NUM_PORTS-1:0] rt_q, rt_nxt;
        logic pop, is_head, is_tail;
        assign is_head = front[v][W-1 -: 2] inside {HEAD, HEADTAIL};
        assign is_tail = front[v][W-1 -: 2] inside {TAIL, HEADTAIL};
        assign pop = pop_any && pop_vc == VC_BITS'(v);
        assign idle[v] = st == IDLE;
        assign active[v] = st == ACTIVE;
        assign disc[v] = idle[v] && !empty[v] && !is_head;
        assign va_req[v] = st == VA_WAIT;
        assign sa_req[v] = active[v] && !empty[v];
        assign vc_route[v] = idle[v] ? '0 : rt_q;
        fifo #(.WIDTH(W), .DEPTH(BUFFER_DEPTH)) u_fifo (
            .clk(clk), .reset(reset), .push(in_valid && in_vc == VC_BITS'(v)), .pop(pop),
            .din(in_flit), .dout(front[v]), .full(full[v]), .empty(empty[v])
        );
        xy_route_compute #(
            .NUM_PORTS(NUM_PORTS), .NUM_ROUTERS(NUM_ROUTERS),
            .ROUTER_PER_ROW(ROUTER_PER_ROW), .ROUTER_ID(ROUTER_ID)
        ) u_xy (.dest(front[v][W-3 -: ROUTER_ID_BITS]), .route(rt_nxt));
        always_comb begin
            st_nxt = st;
            if (st == IDLE && !empty[v] && is_head) st_nxt = VA_WAIT;
            if (st == VA_WAIT && va_grant[v]) st_nxt = ACTIVE;
            if (st == ACTIVE && pop && is_tail) st_nxt = IDLE;
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                st <= IDLE;
                rt_q <= '0;
            end else begin
                st <= st_nxt;
                if (st == IDLE) rt_q <= rt_nxt;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_flit <= '0;
            out_flit_valid <= 1'b0;
            credit_valid <= 1'b0;
            credit_vc <= '0;
            overflow_err <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            out_flit_valid <= rd_ok;
            if (rd_ok) out_flit <= front[rd_vc];
            credit_valid <= pop_any;
            credit_vc <= pop_vc;
            overflow_err <= overflow_err || (in_valid && full[in_vc]);
            protocol_err <= protocol_err || disc_go;
        end
    end
endmodule

// File: tb/tb_vc_input_unit.sv
// tb_vc_input_unit: randomized and directed scoreboard bench against a queue-based packet model
module tb_vc_input_unit;
    import router_pkg::*;
    localparam int NV = 4, DEPTH = 8, W = 32, NP = 5, NR = 16, RPR = 4, RID = 5, VB = 2, RB = 4;
    localparam int P_FREE = 0, P_WAIT = 1, P_OPEN = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] in_flit = '0;
    logic in_valid = 1'b0;
    logic [VB-1:0] in_vc = '0;
    logic [NV-1:0][NP-1:0] vc_route;
    logic [NV-1:0] va_req, sa_req;
    logic [NV-1:0] va_grant = '0;
    logic rd_valid = 1'b0;
    logic [VB-1:0] rd_vc = '0;
    logic [W-1:0] out_flit;
    logic out_flit_valid, credit_valid, overflow_err, protocol_err;
    logic [VB-1:0] credit_vc;

    int checks = 0, failures = 0;
    logic [W-1:0] mq [NV][$];
    int mst [NV];
    logic [NP-1:0] mroute [NV];
    logic m_ovf = 1'b0, m_prot = 1'b0;
    logic [W-1:0] exp_out [$];
    int exp_credit [$];
    int pkt_left [NV];

    always #5 clk = ~clk;

    vc_input_unit #(
        .NUM_VC(NV), .BUFFER_DEPTH(DEPTH), .FLIT_DATA_WIDTH(W), .NUM_PORTS(NP),
        .NUM_ROUTERS(NR), .ROUTER_PER_ROW(RPR), .ROUTER_ID(RID)
    ) dut (
        .clk(clk), .reset(reset), .in_flit(in_flit), .in_valid(in_valid), .in_vc(in_vc),
        .vc_route(vc_route), .va_req(va_req), .va_grant(va_grant), .sa_req(sa_req),
        .rd_valid(rd_valid), .rd_vc(rd_vc), .out_flit(out_flit), .out_flit_valid(out_flit_valid),
        .credit_valid(credit_valid), .credit_vc(credit_vc),
        .overflow_err(overflow_err), .protocol_err(protocol_err)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NP-1:0] xy(int d);
        int dr = d / RPR, dc = d % RPR, mr = RID / RPR, mc = RID % RPR;
        if (dc != mc) return dc > mc ? 5'b01000 : 5'b10000;
        if (dr != mr) return dr > mr ? 5'b00100 : 5'b00010;
        return 5'b00001;
    endfunction

    function automatic logic [W-1:0] mk(logic [1:0] t, int d);
        logic [W-1:0] f;
        f = $urandom;
        f[W-1 -: 2] = t;
        f[W-3 -: RB] = RB'(d);
        return f;
    endfunction

    function automatic logic [W-1:0] next_flit(int v);
        logic [1:0] t;
        if (pkt_left[v] == 0) begin
            pkt_left[v] = $urandom_range(1, 4);
            t = pkt_left[v] == 1 ? HEADTAIL : HEAD;
        end else begin
            t = pkt_left[v] == 1 ? TAIL : BODY;
        end
        pkt_left[v]--;
        return mk(t, $urandom_range(0, NR - 1));
    endfunction

    function automatic bit busy();
        for (int v = 0; v < NV; v++)
            if (mq[v].size() > 0 || mst[v] != P_FREE || pkt_left[v] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Applies one clock edge's worth of packet rules to the model, using pre-edge values.
    task automatic model_update();
        int pre [NV];
        int rv;
        logic rd_ok;
        logic [W-1:0] f;
        if (reset) begin
            for (int v = 0; v < NV; v++) begin
                mq[v].delete();
                mst[v] = P_FREE;
            end
            m_ovf = 1'b0;
            m_prot = 1'b0;
        end else begin
            for (int v = 0; v < NV; v++) pre[v] = mq[v].size();
            rv = int'(rd_vc);
            rd_ok = rd_valid && mst[rv] == P_OPEN && pre[rv] > 0;
            for (int v = 0; v < NV; v++) begin
                if (mst[v] == P_FREE && pre[v] > 0) begin
                    f = mq[v][0];
                    if (f[W-2]) begin
                        mst[v] = P_WAIT;
                        mroute[v] = xy(int'(f[W-3 -: RB]));
                    end else begin
                        void'(mq[v].pop_front());
                        exp_credit.push_back(v);
                        m_prot = 1'b1;
                    end
                end else if (mst[v] == P_WAIT && va_grant[v]) begin
                    mst[v] = P_OPEN;
                end else if (mst[v] == P_OPEN && rd_ok && rv == v) begin
                    f = mq[v].pop_front();
                    exp_out.push_back(f);
                    exp_credit.push_back(v);
                    if (f[W-1]) mst[v] = P_FREE;
                end
            end
            if (in_valid) begin
                if (pre[in_vc] < DEPTH) mq[in_vc].push_back(in_flit);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_status();
        logic [NV-1:0] ev, es;
        logic [NV-1:0][NP-1:0] er;
        for (int v = 0; v < NV; v++) begin
            ev[v] = mst[v] == P_WAIT;
            es[v] = mst[v] == P_OPEN && mq[v].size() > 0;
            er[v] = mst[v] == P_FREE ? '0 : mroute[v];
        end
        chk("status", 64'({va_req, sa_req, vc_route, overflow_err, protocol_err}),
            64'({ev, es, er, m_ovf, m_prot}));
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        va_grant = '0;
        rd_valid = 1'b0;
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic push(int v, logic [W-1:0] f);
        idle_in();
        in_valid = 1'b1;
        in_vc = VB'(v);
        in_flit = f;
        cycle();
    endtask

    task automatic grant(int v);
        idle_in();
        va_grant[v] = 1'b1;
        cycle();
    endtask

    task automatic rd(int v);
        idle_in();
        rd_valid = 1'b1;
        rd_vc = VB'(v);
        cycle();
    endtask

    task automatic nop();
        idle_in();
        cycle();
    endtask

    always @(negedge clk) begin
        if (out_flit_valid) begin
            if (exp_out.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_flit: got unexpected flit %0h expected none", out_flit);
            end else chk("out_flit", 64'(out_flit), 64'(exp_out.pop_front()));
        end
        if (credit_valid) begin
            if (exp_credit.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL credit_vc: got unexpected credit on vc %0d expected none", credit_vc);
            end else chk("credit_vc", 64'(credit_vc), 64'(exp_credit.pop_front()));
        end
    end

    initial begin
        idle_in();
        reset = 1'b1;
        repeat (2) cycle();
        chk("rst_out_flit", 64'(out_flit), 64'(0));
        chk("rst_out_valid", 64'(out_flit_valid), 64'(0));
        chk("rst_credit_valid", 64'(credit_valid), 64'(0));
        reset = 1'b0;

        push(2, mk(HEADTAIL, 7));
        nop();
        chk("route_east", 64'(vc_route[2]), 64'(5'b01000));
        chk("va_req2", 64'(va_req[2]), 64'(1));
        grant(2);
        chk("sa_req2", 64'(sa_req[2]), 64'(1));
        rd(2);
        chk("vc2_idle_route", 64'(vc_route[2]), 64'(0));
        nop();

        push(0, mk(HEADTAIL, 5));
        push(1, mk(HEADTAIL, 1));
        push(2, mk(HEADTAIL, 13));
        push(3, mk(HEADTAIL, 4));
        nop();
        chk("route_local", 64'(vc_route[0]), 64'(5'b00001));
        chk("route_north", 64'(vc_route[1]), 64'(5'b00010));
        chk("route_south", 64'(vc_route[2]), 64'(5'b00100));
        chk("route_west", 64'(vc_route[3]), 64'(5'b10000));
        idle_in();
        va_grant = '1;
        cycle();
        for (int v = 0; v < NV; v++) rd(v);

        push(0, mk(HEAD, 10));
        push(0, mk(BODY, 0));
        push(0, mk(BODY, 0));
        push(0, mk(TAIL, 0));
        grant(0);
        repeat (4) rd(0);
        chk("sa_req0_after_tail", 64'(sa_req[0]), 64'(0));
        nop();

        push(1, mk(HEAD, 2));
        repeat (8) push(1, mk(BODY, 0));
        chk("overflow_err", 64'(overflow_err), 64'(1));
        grant(1);
        repeat (8) rd(1);
        rd(1);
        chk("sa_req1_empty", 64'(sa_req[1]), 64'(0));
        push(1, mk(TAIL, 0));
        rd(1);
        nop();

        push(3, mk(BODY, 0));
        nop();
        chk("protocol_err", 64'(protocol_err), 64'(1));
        chk("va_req3_discard", 64'(va_req[3]), 64'(0));
        rd(3);
        nop();

        push(0, mk(HEAD, 6));
        push(0, mk(BODY, 0));
        push(0, mk(BODY, 0));
        grant(0);
        chk("sa_req0_active", 64'(sa_req[0]), 64'(1));
        idle_in();
        reset = 1'b1;
        rd_valid = 1'b1;
        rd_vc = '0;
        cycle();
        chk("rst_mid_outputs", 64'({va_req, sa_req, vc_route, out_flit_valid, credit_valid,
            overflow_err, protocol_err}), 64'(0));
        chk("rst_mid_out_flit", 64'(out_flit), 64'(0));
        reset = 1'b0;
        nop();

        for (int n = 0; n < 3000; n++) begin
            int v;
            idle_in();
            v = $urandom_range(0, NV - 1);
            if ($urandom_range(0, 3) != 0 && mq[v].size() < DEPTH) begin
                in_valid = 1'b1;
                in_vc = VB'(v);
                in_flit = next_flit(v);
            end
            va_grant = NV'($urandom);
            rd_valid = $urandom_range(0, 3) != 0;
            rd_vc = VB'($urandom_range(0, NV - 1));
            cycle();
        end

        for (int n = 0; n < 2000 && busy(); n++) begin
            idle_in();
            va_grant = '1;
            for (int v = 0; v < NV; v++) begin
                if (pkt_left[v] > 0 && mq[v].size() < DEPTH) begin
                    in_valid = 1'b1;
                    in_vc = VB'(v);
                    in_flit = next_flit(v);
                    break;
                end
            end
            for (int v = 0; v < NV; v++) begin
                if (mst[v] == P_OPEN && mq[v].size() > 0) begin
                    rd_valid = 1'b1;
                    rd_vc = VB'(v);
                    break;
                end
            end
            cycle();
        end
        if (busy()) begin
            checks++;
            failures++;
            $display("FAIL drain: model still holds traffic after cycle bound");
        end
        nop();
        nop();
        chk("out_pending", 64'(exp_out.size()), 64'(0));
        chk("credit_pending", 64'(exp_credit.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
